store_narrower: RTL and testbench

Store-path narrowing unit for the pipelined CPU's memory stage. It is the write-side counterpart of the immediate/load extenders. It takes a 32-bit register value, a byte address and a store width, checks alignment, and replicates the narrowed data into the proper lanes with a 4-bit byte enable. It then issues a single word-aligned write to data memory over a req/ack handshake, stalling the pipeline until the write is acknowledged, rejected or timed out.

---
 rtl/store_narrower.sv | 150 +++++++++++++++
 tb/tb_store_narrower.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_narrower.sv
// store_narrower: memory-stage store path. Checks store alignment, replicates the
// narrowed data into its byte lanes with byte enables, and issues one word-aligned
// write over a req/ack handshake. A watchdog aborts the write if no ack arrives.
module store_narrower #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [1:0]  storeOp,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        memReq,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memByteEn,
  input  logic        memAck,
  output logic        busy,
  output logic        alignErr,
  output logic        timeoutErr,
  output logic [31:0] errAddr
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } stateT;

  stateT           state;
  stateT           stateNext;
  logic [CntW-1:0] cnt;
  logic [1:0]      reqAddrLo;
  logic            accept;
  logic            legal;
  logic            lastCycle;
  logic [31:0]     laneData;
  logic [3:0]      laneBe;

  assign reqReady = (state == IDLE);
  assign busy     = (state == REQ);

  // Legality check and lane replication of the incoming store.
  always_comb begin
    legal    = 1'b0;
    laneData = wdata;
    laneBe   = 4'b0000;
    case (storeOp)
      2'b00: begin
        legal  = (addr[1:0] == 2'b00);
        laneBe = 4'b1111;
      end
      2'b01: begin
        legal    = ~addr[0];
        laneData = {2{wdata[15:0]}};
        laneBe   = addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        legal    = 1'b1;
        laneData = {4{wdata[7:0]}};
        laneBe   = 4'b0001 << addr[1:0];
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Next-state logic; an ack on the final watchdog cycle still completes normally.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    lastCycle = (cnt == CntW'(TIMEOUT - 1));
    case (state)
      IDLE: begin
        if (reqValid) begin
          accept = 1'b1;
          if (legal) stateNext = REQ;
        end
      end
      REQ: begin
        if (memAck || lastCycle) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  // Registered memory-side outputs, watchdog counter and error reporting.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      memReq     <= 1'b0;
      memAddr    <= '0;
      memWdata   <= '0;
      memByteEn  <= '0;
      alignErr   <= 1'b0;
      timeoutErr <= 1'b0;
      errAddr    <= '0;
      cnt        <= '0;
      reqAddrLo  <= '0;
    end else begin
      alignErr   <= 1'b0;
      timeoutErr <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (legal) begin
              memReq    <= 1'b1;
              memAddr   <= {addr[31:2], 2'b00};
              memWdata  <= laneData;
              memByteEn <= laneBe;
              reqAddrLo <= addr[1:0];
              cnt       <= '0;
            end else begin
              alignErr <= 1'b1;
              errAddr  <= addr;
            end
          end
        end
        REQ: begin
          if (memAck) begin
            memReq    <= 1'b0;
            memByteEn <= '0;
            cnt       <= '0;
          end else if (lastCycle) begin
            // Counter is left saturated; the next accept clears it.
            memReq     <= 1'b0;
            memByteEn  <= '0;
            timeoutErr <= 1'b1;
            errAddr    <= {memAddr[31:2], reqAddrLo};
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        default: begin
          memReq    <= 1'b0;
          memByteEn <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrower.sv
// Bench for store_narrower: table-driven stores with a scoreboard checked when
// memReq rises, plus hand-written timeout, reset and stall sequences.
module tb_store_narrower;

  logic        clk = 1'b0;
  logic        resetN;
  logic [1:0]  storeOp;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        reqValidA, reqReadyA, memReqA, memAckA, busyA, alignErrA, timeoutErrA;
  logic [31:0] memAddrA, memWdataA, errAddrA;
  logic [3:0]  memByteEnA;

  logic        reqValidB, reqReadyB, memReqB, memAckB, busyB, alignErrB, timeoutErrB;
  logic [31:0] memAddrB, memWdataB, errAddrB;
  logic [3:0]  memByteEnB;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } expT;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ackDelay;
    bit          legal;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [3:0]  expBe;
  } vecT;

  expT sbQ[$];
  vecT vecs[9];

  always #5 clk = ~clk;

  store_narrower #(.TIMEOUT(255)) dutA (
    .clk(clk), .resetN(resetN), .reqValid(reqValidA), .reqReady(reqReadyA),
    .storeOp(storeOp), .addr(addr), .wdata(wdata), .memReq(memReqA),
    .memAddr(memAddrA), .memWdata(memWdataA), .memByteEn(memByteEnA),
    .memAck(memAckA), .busy(busyA), .alignErr(alignErrA),
    .timeoutErr(timeoutErrA), .errAddr(errAddrA)
  );

  store_narrower #(.TIMEOUT(4)) dutB (
    .clk(clk), .resetN(resetN), .reqValid(reqValidB), .reqReady(reqReadyB),
    .storeOp(storeOp), .addr(addr), .wdata(wdata), .memReq(memReqB),
    .memAddr(memAddrB), .memWdata(memWdataB), .memByteEn(memByteEnB),
    .memAck(memAckB), .busy(busyB), .alignErr(alignErrB),
    .timeoutErr(timeoutErrB), .errAddr(errAddrB)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rising memReq on dutA must match the oldest pushed store.
  logic prevReqA = 1'b0;
  always @(negedge clk) begin
    if (!resetN) begin
      prevReqA <= 1'b0;
    end else begin
      if (memReqA && !prevReqA) begin
        if (sbQ.size() == 0) begin
          chk("unexpected_memReq", 32'(memReqA), 32'd0);
        end else begin
          expT e;
          e = sbQ.pop_front();
          chk("sb_memAddr", memAddrA, e.a);
          chk("sb_memWdata", memWdataA, e.d);
          chk("sb_memByteEn", 32'(memByteEnA), 32'(e.be));
        end
      end
      prevReqA <= memReqA;
    end
  end

  task automatic doStoreA(input vecT v);
    storeOp   = v.op;
    addr      = v.addr;
    wdata     = v.wdata;
    reqValidA = 1'b1;
    chk("reqReady_before", 32'(reqReadyA), 32'd1);
    if (v.legal) sbQ.push_back('{a: v.expAddr, d: v.expWdata, be: v.expBe});
    tick();
    reqValidA = 1'b0;
    if (v.legal) begin
      chk("busy_in_req", 32'(busyA), 32'd1);
      chk("reqReady_in_req", 32'(reqReadyA), 32'd0);
      chk("alignErr_legal", 32'(alignErrA), 32'd0);
      repeat (v.ackDelay) begin
        tick();
        chk("memReq_wait", 32'(memReqA), 32'd1);
      end
      memAckA = 1'b1;
      tick();
      memAckA = 1'b0;
      chk("memReq_after_ack", 32'(memReqA), 32'd0);
      chk("reqReady_after_ack", 32'(reqReadyA), 32'd1);
      chk("byteEn_after_ack", 32'(memByteEnA), 32'd0);
      chk("busy_after_ack", 32'(busyA), 32'd0);
      chk("wdata_hold_idle", memWdataA, v.expWdata);
    end else begin
      chk("alignErr_pulse", 32'(alignErrA), 32'd1);
      chk("errAddr_align", errAddrA, v.addr);
      chk("memReq_illegal", 32'(memReqA), 32'd0);
      chk("busy_illegal", 32'(busyA), 32'd0);
      chk("reqReady_illegal", 32'(reqReadyA), 32'd1);
      tick();
      chk("alignErr_drop", 32'(alignErrA), 32'd0);
      chk("memReq_illegal2", 32'(memReqA), 32'd0);
    end
  endtask

  initial begin
    int n;
    vecT v;

    vecs[0] = '{2'b10, 32'h0000_1003, 32'h1234_56AB, 3, 1'b1, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000};
    vecs[1] = '{2'b01, 32'h0000_2002, 32'hDEAD_BEEF, 0, 1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100};
    vecs[2] = '{2'b00, 32'h0000_0010, 32'hCAFE_F00D, 1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'b1111};
    vecs[3] = '{2'b00, 32'h0000_0006, 32'h1111_1111, 0, 1'b0, 32'h0, 32'h0, 4'b0000};
    vecs[4] = '{2'b01, 32'h0000_0001, 32'h2222_2222, 0, 1'b0, 32'h0, 32'h0, 4'b0000};
    vecs[5] = '{2'b11, 32'h0000_0020, 32'h3333_3333, 0, 1'b0, 32'h0, 32'h0, 4'b0000};
    vecs[6] = '{2'b10, 32'h0000_3001, 32'h0000_00C5, 0, 1'b1, 32'h0000_3000, 32'hC5C5_C5C5, 4'b0010};
    vecs[7] = '{2'b01, 32'h0000_4000, 32'h5566_1234, 2, 1'b1, 32'h0000_4000, 32'h1234_1234, 4'b0011};
    vecs[8] = '{2'b10, 32'h0000_5002, 32'h0000_0099, 1, 1'b1, 32'h0000_5000, 32'h9999_9999, 4'b0100};

    resetN = 1'b1; storeOp = '0; addr = '0; wdata = '0;
    reqValidA = 1'b0; memAckA = 1'b0; reqValidB = 1'b0; memAckB = 1'b0;
    #2 resetN = 1'b0;
    #1;
    chk("rst_memReq", 32'(memReqA), 32'd0);
    chk("rst_memAddr", memAddrA, 32'd0);
    chk("rst_memWdata", memWdataA, 32'd0);
    chk("rst_byteEn", 32'(memByteEnA), 32'd0);
    chk("rst_alignErr", 32'(alignErrA), 32'd0);
    chk("rst_timeoutErr", 32'(timeoutErrA), 32'd0);
    chk("rst_errAddr", errAddrA, 32'd0);
    chk("rst_reqReady", 32'(reqReadyA), 32'd1);
    chk("rst_busy", 32'(busyA), 32'd0);
    #10 resetN = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) doStoreA(vecs[i]);

    // Watchdog abort on the short-timeout instance.
    storeOp = 2'b10; addr = 32'h0000_0082; wdata = 32'h0000_0077;
    reqValidB = 1'b1;
    tick();
    reqValidB = 1'b0;
    n = 0;
    while (memReqB && n < 8) begin
      n++;
      tick();
    end
    chk("timeout_req_cycles", 32'(n), 32'd4);
    chk("timeoutErr_pulse", 32'(timeoutErrB), 32'd1);
    chk("timeout_errAddr", errAddrB, 32'h0000_0082);
    chk("timeout_byteEn", 32'(memByteEnB), 32'd0);
    chk("timeout_reqReady", 32'(reqReadyB), 32'd1);
    tick();
    chk("timeoutErr_drop", 32'(timeoutErrB), 32'd0);

    // Ack on the final watchdog cycle wins.
    storeOp = 2'b00; addr = 32'h0000_0090; wdata = 32'h0102_0304;
    reqValidB = 1'b1;
    tick();
    reqValidB = 1'b0;
    repeat (3) tick();
    chk("last_cycle_memReq", 32'(memReqB), 32'd1);
    memAckB = 1'b1;
    tick();
    memAckB = 1'b0;
    chk("last_ack_memReq", 32'(memReqB), 32'd0);
    chk("last_ack_noTimeout", 32'(timeoutErrB), 32'd0);
    tick();
    chk("last_ack_noTimeout2", 32'(timeoutErrB), 32'd0);
    chk("last_ack_errAddr", errAddrB, 32'h0000_0082);

    // Reset asserted mid-write.
    storeOp = 2'b00; addr = 32'h0000_0040; wdata = 32'h0BAD_F00D;
    reqValidA = 1'b1;
    sbQ.push_back('{a: 32'h0000_0040, d: 32'h0BAD_F00D, be: 4'b1111});
    tick();
    reqValidA = 1'b0;
    tick();
    chk("pre_rst_memReq", 32'(memReqA), 32'd1);
    #2 resetN = 1'b0;
    #1;
    chk("midrst_memReq", 32'(memReqA), 32'd0);
    chk("midrst_memAddr", memAddrA, 32'd0);
    chk("midrst_memWdata", memWdataA, 32'd0);
    chk("midrst_byteEn", 32'(memByteEnA), 32'd0);
    chk("midrst_timeoutErr", 32'(timeoutErrA), 32'd0);
    chk("midrst_alignErr", 32'(alignErrA), 32'd0);
    chk("midrst_errAddr", errAddrA, 32'd0);
    chk("midrst_reqReady", 32'(reqReadyA), 32'd1);
    #2 resetN = 1'b1;
    tick();
    v = '{2'b00, 32'h0000_0050, 32'h5A5A_5A5A, 1, 1'b1, 32'h0000_0050, 32'h5A5A_5A5A, 4'b1111};
    doStoreA(v);

    // Long stall: outputs stable and new requests refused.
    storeOp = 2'b00; addr = 32'h0000_0044; wdata = 32'h1122_3344;
    reqValidA = 1'b1;
    sbQ.push_back('{a: 32'h0000_0044, d: 32'h1122_3344, be: 4'b1111});
    tick();
    reqValidA = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_busy", 32'(busyA), 32'd1);
      chk("stall_memReq", 32'(memReqA), 32'd1);
      chk("stall_memAddr", memAddrA, 32'h0000_0044);
      chk("stall_memWdata", memWdataA, 32'h1122_3344);
      chk("stall_byteEn", 32'(memByteEnA), 32'hF);
      if (i == 5) begin
        storeOp = 2'b00; addr = 32'h0000_0088; wdata = 32'hFFFF_FFFF;
        reqValidA = 1'b1;
      end else begin
        reqValidA = 1'b0;
      end
      tick();
    end
    reqValidA = 1'b0;
    memAckA = 1'b1;
    tick();
    memAckA = 1'b0;
    chk("stall_ack_memReq", 32'(memReqA), 32'd0);
    chk("stall_addr_hold", memAddrA, 32'h0000_0044);
    chk("stall_no_timeout", 32'(timeoutErrA), 32'd0);
    tick();
    chk("stall_no_accept", 32'(memReqA), 32'd0);
    chk("sb_queue_empty", 32'(sbQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
